// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state type and default sizing for the FIR sequencing controller
package fir_pkg;

  localparam int FIR_ADDR_W  = 8;
  localparam int FIR_MAC_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } fir_ctrl_state_t;

endpackage

// File: rtl/fir_tap_counter.sv
// rtl/fir_tap_counter.sv - loadable up-counter with terminal-match flag
module fir_tap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         match
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign match = (cnt_q == term);

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR sample/tap sequencer: delay-line write, tap stepping, MAC drain, result handshake
// Optional FIR_SEQ_CTRL_PERF_EN adds a 16-bit completed-result counter port sample_cnt.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int ADDR_W  = FIR_ADDR_W,
  parameter int MAC_LAT = FIR_MAC_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] taps_m1,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef FIR_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]       sample_cnt
`endif
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  fir_ctrl_state_t   state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] taps_q, taps_d;

  logic              accept;
  logic [ADDR_W-1:0] k;
  logic              k_last;
  logic [DW-1:0]     drain_cnt;
  logic              drain_last;

  assign accept = (state_q == IDLE) && in_valid;

  fir_tap_counter #(.W(ADDR_W)) u_tap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .inc      ((state_q == MAC) && !k_last),
    .term     (taps_q),
    .cnt      (k),
    .match    (k_last)
  );

  // Drain count is cleared on the last tap so DRAIN lasts exactly MAC_LAT cycles.
  fir_tap_counter #(.W(DW)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == MAC) && k_last),
    .load_val ('0),
    .inc      ((state_q == DRAIN) && !drain_last),
    .term     (DW'(MAC_LAT - 1)),
    .cnt      (drain_cnt),
    .match    (drain_last)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    base_d    = base_q;
    taps_d    = taps_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    rd_addr   = '0;
    coef_addr = '0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    out_valid = 1'b0;
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_addr  = wr_ptr_q;
          base_d   = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          taps_d   = taps_m1;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_en    = 1'b1;
        acc_clr   = (k == '0);
        coef_addr = k;
        rd_addr   = base_q - k;
        if (k_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      base_q   <= '0;
      taps_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      base_q   <= base_d;
      taps_q   <= taps_d;
    end
  end

`ifdef FIR_SEQ_CTRL_PERF_EN
  logic [15:0] sample_cnt_q, sample_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if ((state_q == OUT) && out_ready) begin
      sample_cnt_d = sample_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
`else
  logic unused_drain;
  assign unused_drain = ^drain_cnt;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - randomized and directed self-check of fir_seq_ctrl against an operation-level model
module tb_fir_seq_ctrl;

  localparam int AW   = 4;
  localparam int ML   = 2;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] taps_m1;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] coef_addr;
  logic          acc_clr;
  logic          acc_en;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef FIR_SEQ_CTRL_PERF_EN
  logic [15:0]   sample_cnt;
`endif

  always #5 clk = ~clk;

  fir_seq_ctrl #(.ADDR_W(AW), .MAC_LAT(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .taps_m1   (taps_m1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .coef_addr (coef_addr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef FIR_SEQ_CTRL_PERF_EN
    ,
    .sample_cnt(sample_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operation-level model: t counts cycles since accept, n taps per operation.
  bit m_active = 0;
  int m_t      = 0;
  int m_n      = 0;
  int m_base   = 0;
  int m_wp     = 0;
  int m_cnt    = 0;
  bit chk_en   = 0;

  logic          obs_ov;
  logic [AW-1:0] obs_wr_addr;
  logic [AW-1:0] obs_rd_addr;

  task automatic step(input bit rst, input bit iv, input int tm1, input bit ordy);
    bit inmac;
    int e_rd;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    taps_m1   = AW'(tm1);
    out_ready = ordy;
    #1;
    inmac = m_active && (m_t <= m_n);
    e_rd  = inmac ? ((m_base - (m_t - 1)) & MASK) : 0;
    if (chk_en) begin
      check("in_ready",  in_ready,  !m_active);
      check("busy",      busy,      m_active);
      check("wr_en",     wr_en,     !m_active && iv);
      check("wr_addr",   wr_addr,   (!m_active && iv) ? m_wp : 0);
      check("acc_en",    acc_en,    inmac);
      check("acc_clr",   acc_clr,   inmac && (m_t == 1));
      check("coef_addr", coef_addr, inmac ? (m_t - 1) : 0);
      check("rd_addr",   rd_addr,   e_rd);
      check("out_valid", out_valid, m_active && (m_t > m_n + ML));
`ifdef FIR_SEQ_CTRL_PERF_EN
      check("sample_cnt", sample_cnt, m_cnt);
`endif
    end
    obs_ov      = out_valid;
    obs_wr_addr = wr_addr;
    obs_rd_addr = rd_addr;
    if (rst) begin
      m_active = 0;
      m_wp     = 0;
      m_t      = 0;
      m_cnt    = 0;
      chk_en   = 1;
    end else if (!m_active) begin
      if (iv) begin
        m_active = 1;
        m_t      = 1;
        m_n      = tm1 + 1;
        m_base   = m_wp;
        m_wp     = (m_wp + 1) & MASK;
      end
    end else if (m_t > m_n + ML) begin
      if (ordy) begin
        m_active = 0;
        m_cnt    = (m_cnt + 1) & 16'hFFFF;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic latency_op(input int tm1);
    int lat;
    lat = 0;
    step(0, 1, tm1, 0);
    do begin
      step(0, 0, $urandom_range(MASK), 0);
      lat++;
    end while (!obs_ov && lat < 100);
    check("latency", lat, tm1 + 2 + ML);
    repeat (5) step(0, $urandom_range(1), $urandom_range(MASK), 0);
    step(0, 0, 0, 1);
  endtask

  task automatic finish_op(input bit rand_iv);
    int guard;
    guard = 0;
    while (m_active && guard < 200) begin
      step(0, rand_iv ? 1'($urandom_range(1)) : 1'b0, $urandom_range(MASK), 1);
      guard++;
    end
    check("op_done", guard < 200, 1);
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    latency_op(3);
    latency_op(0);

    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 3, 1);
      check("b2b_wr_addr", obs_wr_addr, i & MASK);
      if (i == 16) begin
        step(0, 0, 3, 1);
        step(0, 0, 3, 1);
        check("wrap_rd_k1", obs_rd_addr, 15);
      end
      finish_op(0);
    end

    step(0, 1, 5, 0);
    step(0, 0, 5, 0);
    step(0, 0, 5, 0);
    step(1, 0, 5, 0);
    step(0, 0, 5, 0);
    step(0, 1, 2, 0);
    check("post_reset_wr_addr", obs_wr_addr, 0);
    finish_op(0);

    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2, 0);
      finish_op(1);
    end
    step(0, 1, 1, 0);
    check("perf_wr_addr", obs_wr_addr, 3);
`ifdef FIR_SEQ_CTRL_PERF_EN
    check("perf_sample_cnt", sample_cnt, 3);
`endif
    finish_op(0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(199) == 0, 1'($urandom_range(1)), $urandom_range(MASK),
           1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
